// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle divider: state encoding,
// iteration count and datapath width.
package div_unit_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    typedef enum logic [1:0] {
        ST_FREE   = DIV_FREE,
        ST_BYZERO = DIV_BYZERO,
        ST_ON     = DIV_ON,
        ST_END    = DIV_END
    } div_state_e;

    // Two's-complement negate when n is set.
    function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] x);
        return n ? (~x + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 divide iteration: shift in a dividend bit, trial
// subtract the divisor magnitude, keep the difference when there is no borrow.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next_c,
    output logic              q_bit_c
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] trial;
    logic            borrow;

    // A set top bit in partial means it already exceeds any 32-bit divisor.
    always_comb begin
        partial    = {rem, bit_in};
        trial      = partial - {1'b0, divisor};
        borrow     = ~partial[DATA_W] & trial[DATA_W];
        q_bit_c    = ~borrow;
        rem_next_c = borrow ? partial[DATA_W-1:0] : trial[DATA_W-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// 32-iteration restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Optional macro DIV_BYZERO_EN: zero divisor short-cuts to a zero result.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] rem;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] rem_next_c;
    logic              q_bit_c;
    logic [DATA_W-1:0] quot_next_c;

    div_step u_step (
        .rem        (rem),
        .bit_in     (dividend[DATA_W-1]),
        .divisor    (divisor),
        .rem_next_c (rem_next_c),
        .q_bit_c    (q_bit_c)
    );

    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    assign quot_next_c = {dividend[DATA_W-2:0], q_bit_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    cnt      <= '0;
                    if (start_i && !annul_i) begin
                        dividend <= neg_if(signed_div_i & opdata1_i[31], opdata1_i);
                        divisor  <= neg_if(signed_div_i & opdata2_i[31], opdata2_i);
                        rem      <= '0;
                        neg_q    <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r    <= signed_div_i & opdata1_i[31];
`ifdef DIV_BYZERO_EN
                        state    <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
`else
                        state    <= ST_ON;
`endif
                    end
                end
`ifdef DIV_BYZERO_EN
                ST_BYZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        state   <= ST_FREE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= ST_END;
                        ready_o <= 1'b1;
                    end
                end
`endif
                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        cnt      <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        rem      <= rem_next_c;
                        dividend <= quot_next_c;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DIV_ITER - 1)) begin
                            state    <= ST_END;
                            ready_o  <= 1'b1;
                            result_o <= {neg_if(neg_r, rem_next_c), neg_if(neg_q, quot_next_c)};
                        end
                    end
                end
                ST_END: begin
                    if (annul_i || !start_i) begin
                        state    <= ST_FREE;
                        cnt      <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    state    <= ST_FREE;
                    cnt      <= '0;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model and an
// every-cycle output comparison.
module tb_div_unit;

`ifdef DIV_BYZERO_EN
    localparam bit BYZ = 1'b1;
`else
    localparam bit BYZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_chk = 0;
    int n_err = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: divide magnitudes, then apply sign rules.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ma, mb, q, r;
        bit na, nb;
        na = s && a[31];
        nb = s && b[31];
        ma = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        mb = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        if (mb == 0) begin
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level timing model: idle / busy with a countdown / done.
    int          mdl_phase = 0;
    int          mdl_left  = 0;
    logic [63:0] mdl_res   = '0;
    bit          mdl_on    = 1'b0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_res   = '0;

    always @(posedge clk) begin
        if (rst) begin
            mdl_on    = 1'b1;
            mdl_phase = 0;
            exp_ready = 1'b0;
            exp_res   = '0;
        end else begin
            case (mdl_phase)
                0: if (start_i && !annul_i) begin
                    mdl_phase = 1;
                    if (BYZ && opdata2_i == 32'h0) begin
                        mdl_left = 1;
                        mdl_res  = '0;
                    end else begin
                        mdl_left = 32;
                        mdl_res  = ref_div(signed_div_i, opdata1_i, opdata2_i);
                    end
                end
                1: if (annul_i) begin
                    mdl_phase = 0;
                end else begin
                    mdl_left--;
                    if (mdl_left == 0) begin
                        mdl_phase = 2;
                        exp_ready = 1'b1;
                        exp_res   = mdl_res;
                    end
                end
                default: if (annul_i || !start_i) begin
                    mdl_phase = 0;
                    exp_ready = 1'b0;
                    exp_res   = '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("cyc_ready", {63'h0, ready_o}, {63'h0, exp_ready});
            chk("cyc_result", result_o, exp_res);
        end
    end

    task automatic go(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Returns number of edges after the start edge until ready; scrambles operands meanwhile.
    task automatic wait_ready(output int lat);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!ready_o) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
        end while (!ready_o && cyc < 64);
        lat = cyc - 1;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", {63'h0, ready_o}, 64'h0);
        chk("drop_result", result_o, 64'h0);
    endtask

    task automatic run(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [63:0] exp_val);
        int lat;
        go(s, a, b);
        wait_ready(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, result_o, exp_val);
        release_start();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required end before 200000)", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;

        // Pin the reference model itself.
        chk("model_u100_7",  ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_s_m7_2",  ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_s_7_m2",  ref_div(1'b1, 32'd7, 32'hFFFF_FFFE), {32'h0000_0001, 32'hFFFF_FFFD});
        chk("model_s_min_m1", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});
        chk("model_u_zero",  ref_div(1'b0, 32'h1234_5678, 32'h0), {32'h1234_5678, 32'hFFFF_FFFF});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {63'h0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);

        // 100/7 with start held five cycles in END.
        go(1'b0, 32'd100, 32'd7);
        wait_ready(lat);
        chk("u100_7_lat", 64'(lat), 64'd32);
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready", {63'h0, ready_o}, 64'h1);
            chk("hold_result", result_o, {32'd2, 32'd14});
            if (i < 4) @(negedge clk);
        end
        release_start();

        run("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32, {32'h0000_0001, 32'hFFFF_FFFD});
        run("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, {32'h0, 32'h8000_0000});
        run("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32, {32'hFFFF_FFFE, 32'h0000_000E});
        run("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1, 32, {32'h0, 32'hFFFF_FFFF});
        run("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, {32'h0, 32'h1});
        run("u_5_9",    1'b0, 32'd5, 32'd9, 32, {32'd5, 32'd0});

        if (BYZ) begin
            run("u_zero", 1'b0, 32'h1234_5678, 32'h0, 1, 64'h0);
            run("s_zero", 1'b1, 32'hFFFF_FFF8, 32'h0, 1, 64'h0);
        end else begin
            run("u_zero", 1'b0, 32'h1234_5678, 32'h0, 32, {32'h1234_5678, 32'hFFFF_FFFF});
            run("s_zero", 1'b1, 32'hFFFF_FFF8, 32'h0, 32, {32'hFFFF_FFF8, 32'h0000_0001});
        end

        // Start together with annul in FREE is ignored.
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        chk("annul_free_no_ready", 64'(seen), 64'd0);

        // Annul at iteration 10, then immediate restart 9/3.
        go(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul10_ready", {63'h0, ready_o}, 64'h0);
        chk("annul10_result", result_o, 64'h0);
        opdata1_i = 32'd9; opdata2_i = 32'd3; signed_div_i = 1'b0;
        wait_ready(lat);
        chk("restart_lat", 64'(lat), 64'd32);
        chk("restart_res", result_o, {32'd0, 32'd3});
        release_start();

        // Annul coinciding with the final iteration: no ready pulse.
        go(1'b0, 32'd100, 32'd7);
        seen = 0;
        repeat (32) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        if (ready_o) seen++;
        repeat (5) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        chk("annul_last_no_ready", 64'(seen), 64'd0);

        // Reset at iteration 20.
        go(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_mid_result", result_o, 64'h0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        chk("rst_no_spurious", 64'(seen), 64'd0);

        // Divider still works after the mid-divide reset.
        run("post_rst", 1'b0, 32'd1000, 32'd33, 32, {32'd10, 32'd30});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
